// File: rtl/db_pkg.sv
// Shared types and defaults for the switch debouncer.
package db_pkg;

  // Default counter width: 2^21-1 clocks at 50 MHz is about 41.9 ms.
  localparam int unsigned DB_N_DEFAULT = 21;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

endpackage

// File: rtl/db_if.sv
// Debouncer signal bundle: raw switch in, clean level and rising-edge tick out.
interface db_if;
  logic sw;
  logic db_level;
  logic db_tick;

  modport master (output sw, input db_level, input db_tick);
  modport slave  (input sw, output db_level, output db_tick);
endinterface

// File: rtl/db_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to 0.
module db_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/db_debounce.sv
// Switch/push-button debouncer: four-state FSM plus an N-bit down-counter.
// Define DB_SYNC_EN to pass sw through a 2-FF synchronizer first (+2 cycles latency).
module db_debounce
  import db_pkg::*;
#(
  parameter int unsigned N = DB_N_DEFAULT
) (
  input logic clk,
  input logic reset,
  db_if.slave bus
);

  db_state_e    state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] q_dec;
  logic         sw_s;
  logic         tick;

`ifdef DB_SYNC_EN
  db_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw),
    .q     (sw_s)
  );
`else
  // Caller guarantees sw is already synchronous to clk.
  assign sw_s = bus.sw;
`endif

  assign q_dec = q_q - N'(1);

  // Next-state, counter and Mealy tick decode.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tick    = 1'b0;
    unique case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          q_d     = '1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else begin
          q_d = q_dec;
          // Exit at q-1==0 so the counter never wraps.
          if (q_dec == '0) begin
            state_d = ONE;
            tick    = 1'b1;
          end
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          q_d     = '1;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
        end else begin
          q_d = q_dec;
          if (q_dec == '0) begin
            state_d = ZERO;
          end
        end
      end
      default: state_d = ZERO;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ZERO;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // Level is a pure state decode, so it cannot glitch on counter activity.
  assign bus.db_level = (state_q == ONE) || (state_q == WAIT0);
  assign bus.db_tick  = tick;

endmodule

// File: tb/tb_db_debounce.sv
// Directed bench for db_debounce at N=4 (stable interval 15 clocks).
module tb_db_debounce;
  import db_pkg::*;

  localparam int unsigned N = 4;
`ifdef DB_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   ticks = 0;
  int   t0;

  always #10 clk = ~clk;

  db_if bus ();

  db_debounce #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Count every edge that sees db_tick high.
  always @(posedge clk) if (bus.db_tick === 1'b1) ticks++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with sw=1, then accepted press after release.
    reset  = 1'b0;
    bus.sw = 1'b1;
    step(3);
    check("rst_level", 32'(bus.db_level), 32'd0);
    check("rst_tick", 32'(bus.db_tick), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ZERO));
    reset = 1'b1;
    t0 = ticks;
    step(14 + L);
    check("t1_pre_tick", 32'(bus.db_tick), 32'd0);
    step(1);
    check("t1_level_15", 32'(bus.db_level), 32'd0);
    check("t1_tick_15", 32'(bus.db_tick), 32'd1);
    step(1);
    check("t1_level_16", 32'(bus.db_level), 32'd1);
    check("t1_tick_16", 32'(bus.db_tick), 32'd0);
    check("t1_ticks", 32'(ticks - t0), 32'd1);

    // 4: release bounce from ONE, then a held release.
    t0 = ticks;
    for (int r = 0; r < 3; r++) begin
      bus.sw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        check("t4_bounce_lvl0", 32'(bus.db_level), 32'd1);
      end
      bus.sw = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step(1);
        check("t4_bounce_lvl1", 32'(bus.db_level), 32'd1);
      end
    end
    bus.sw = 1'b0;
    step(15 + L);
    check("t4_level_15", 32'(bus.db_level), 32'd1);
    step(1);
    check("t4_level_16", 32'(bus.db_level), 32'd0);
    check("t4_ticks", 32'(ticks - t0), 32'd0);

    // 2: press bounce from ZERO never reaches ONE or ticks.
    t0 = ticks;
    for (int r = 0; r < 3; r++) begin
      bus.sw = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step(1);
        check("t2_bounce_lvl1", 32'(bus.db_level), 32'd0);
        check("t2_bounce_tick", 32'(bus.db_tick), 32'd0);
      end
      bus.sw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        check("t2_bounce_lvl0", 32'(bus.db_level), 32'd0);
      end
    end
    step(4);
    check("t2_state", 32'(dut.state_q), 32'(ZERO));
    check("t2_ticks", 32'(ticks - t0), 32'd0);

    // 3: press held 50 cycles gives one tick and a stable high level.
    t0 = ticks;
    bus.sw = 1'b1;
    step(15 + L);
    check("t3_level_15", 32'(bus.db_level), 32'd0);
    check("t3_tick_15", 32'(bus.db_tick), 32'd1);
    step(1);
    check("t3_level_16", 32'(bus.db_level), 32'd1);
    step(34 - L);
    check("t3_level_50", 32'(bus.db_level), 32'd1);
    check("t3_ticks", 32'(ticks - t0), 32'd1);

    // 5: reset asserted mid-WAIT0 drops the level at once.
    bus.sw = 1'b0;
    step(5);
    check("t5_wait0_lvl", 32'(bus.db_level), 32'd1);
    check("t5_wait0_state", 32'(dut.state_q), 32'(WAIT0));
    reset = 1'b0;
    #1;
    check("t5_async_lvl", 32'(bus.db_level), 32'd0);
    check("t5_async_tick", 32'(bus.db_tick), 32'd0);
    check("t5_async_state", 32'(dut.state_q), 32'(ZERO));
    step(2);
    reset = 1'b1;
    t0 = ticks;
    step(20);
    check("t5_after_lvl", 32'(bus.db_level), 32'd0);
    check("t5_ticks", 32'(ticks - t0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
